// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and helpers for the IF/DM single-port SRAM arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic {IDLE, ACCESS} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  localparam logic [3:0] BE_N_ALL  = 4'b0000;
  localparam logic [3:0] BE_N_NONE = 4'b1111;

  // Byte address to word address; the caller truncates to its SRAM width.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Pipeline memory ports plus external SRAM pins of the arbiter.
interface sram_port_arbiter_if #(parameter int ADDR_W = 20);
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [31:0]       dm_addr_i;
    logic [3:0]        dm_wbe_n_i;
    logic [31:0]       dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [31:0]       dm_rdata_o;
    logic              sram_ce_n_o;
    logic              sram_we_n_o;
    logic [3:0]        sram_be_n_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
               sram_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
               sram_ce_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o, sram_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
               sram_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
               sram_ce_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Grant decision: DM first, but IF is forced through after MAX_DM_RUN DM grants in a row.
module sram_arb_pick #(
    parameter int MAX_DM_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic if_req,
    input  logic dm_req,
    output logic gnt_if,
    output logic gnt_dm
);
    localparam int RW = $clog2(MAX_DM_RUN + 1);

    logic [RW-1:0] dm_run_q;
    logic          if_forced;

    assign if_forced = if_req && (dm_run_q == RW'(MAX_DM_RUN));

    always_comb begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
        if (en && !rst) begin
            if (dm_req && !if_forced) gnt_dm = 1'b1;
            else if (if_req)          gnt_if = 1'b1;
        end
    end

    // Only counts DM wins that actually made IF wait.
    always_ff @(posedge clk) begin
        if (rst)
            dm_run_q <= '0;
        else if (gnt_if || !if_req)
            dm_run_q <= '0;
        else if (gnt_dm && dm_run_q != RW'(MAX_DM_RUN))
            dm_run_q <= dm_run_q + 1'b1;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between the IF and DM requesters.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int SRAM_LAT   = 2,
    parameter int ADDR_W     = 20,
    parameter int MAX_DM_RUN = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);
    localparam int CW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic [CW-1:0]     cnt_q;
    logic              we_q;
    logic [3:0]        wbe_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              if_rvalid_q, dm_rvalid_q;
    logic [31:0]       if_rdata_q, dm_rdata_q;
    logic              gnt_if, gnt_dm, done;
    logic              ce_n, we_n;
    logic [3:0]        be_n;

    sram_arb_pick #(.MAX_DM_RUN(MAX_DM_RUN)) u_pick (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == IDLE),
        .if_req (bus.if_req_i),
        .dm_req (bus.dm_req_i),
        .gnt_if (gnt_if),
        .gnt_dm (gnt_dm)
    );

    assign done = (state_q == ACCESS) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        ce_n    = 1'b1;
        we_n    = 1'b1;
        be_n    = BE_N_NONE;
        case (state_q)
            IDLE:   if (gnt_if || gnt_dm) state_d = ACCESS;
            ACCESS: begin
                if (done) state_d = IDLE;
                we_n = !we_q;
                be_n = we_q ? wbe_n_q : BE_N_ALL;
                // A write with no bytes enabled never selects the chip.
                ce_n = we_q && (wbe_n_q == BE_N_NONE);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DM;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wbe_n_q     <= BE_N_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if (gnt_dm) begin
                owner_q <= OWN_DM;
                we_q    <= bus.dm_we_i;
                wbe_n_q <= bus.dm_wbe_n_i;
                addr_q  <= ADDR_W'(word_addr(bus.dm_addr_i));
                wdata_q <= bus.dm_wdata_i;
                cnt_q   <= CW'(SRAM_LAT - 1);
            end else if (gnt_if) begin
                owner_q <= OWN_IF;
                we_q    <= 1'b0;
                wbe_n_q <= BE_N_ALL;
                addr_q  <= ADDR_W'(word_addr(bus.if_addr_i));
                cnt_q   <= CW'(SRAM_LAT - 1);
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done) begin
                if (owner_q == OWN_DM) begin
                    dm_rvalid_q <= 1'b1;
                    if (!we_q) dm_rdata_q <= bus.sram_rdata_i;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.sram_rdata_i;
                end
            end
        end
    end

    assign bus.if_gnt_o     = gnt_if;
    assign bus.dm_gnt_o     = gnt_dm;
    assign bus.if_rvalid_o  = if_rvalid_q;
    assign bus.dm_rvalid_o  = dm_rvalid_q;
    assign bus.if_rdata_o   = if_rdata_q;
    assign bus.dm_rdata_o   = dm_rdata_q;
    assign bus.sram_ce_n_o  = ce_n;
    assign bus.sram_we_n_o  = we_n;
    assign bus.sram_be_n_o  = be_n;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_wdata_o = wdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: SRAM_LAT=2 arbiter (dut_a) plus an SRAM_LAT=1 arbiter (dut_b) for throughput.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   ng;
    logic [5:0] seq;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(20)) bus_a ();
    sram_port_arbiter_if #(.ADDR_W(20)) bus_b ();

    sram_port_arbiter #(.SRAM_LAT(2), .ADDR_W(20), .MAX_DM_RUN(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    sram_port_arbiter #(.SRAM_LAT(1), .ADDR_W(20), .MAX_DM_RUN(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    // SRAM model for dut_a: word i initialised to 0x1000_0000 + i, byte-masked writes.
    logic [31:0] mem_a [64];
    assign bus_a.sram_rdata_i = mem_a[bus_a.sram_addr_o[5:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'h1000_0000 + i;
        end else if (!bus_a.sram_ce_n_o && !bus_a.sram_we_n_o) begin
            for (int b = 0; b < 4; b++)
                if (!bus_a.sram_be_n_o[b])
                    mem_a[bus_a.sram_addr_o[5:0]][8*b +: 8] <= bus_a.sram_wdata_o[8*b +: 8];
        end
    end

    // dut_b read-only SRAM: data = 0x2000_0000 | word address.
    assign bus_b.sram_rdata_i = 32'h2000_0000 | {12'h000, bus_b.sram_addr_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        bus_a.if_req_i = 0; bus_a.if_addr_i = 0; bus_a.dm_req_i = 0; bus_a.dm_we_i = 0;
        bus_a.dm_addr_i = 0; bus_a.dm_wbe_n_i = 4'hF; bus_a.dm_wdata_i = 0;
        bus_b.if_req_i = 0; bus_b.if_addr_i = 0; bus_b.dm_req_i = 0; bus_b.dm_we_i = 0;
        bus_b.dm_addr_i = 0; bus_b.dm_wbe_n_i = 4'hF; bus_b.dm_wdata_i = 0;
        repeat (2) clk_step();
        mem_init = 1'b0;
        #1;
        chk("rst_if_gnt",    bus_a.if_gnt_o,     0);
        chk("rst_dm_gnt",    bus_a.dm_gnt_o,     0);
        chk("rst_if_rvalid", bus_a.if_rvalid_o,  0);
        chk("rst_dm_rvalid", bus_a.dm_rvalid_o,  0);
        chk("rst_if_rdata",  bus_a.if_rdata_o,   0);
        chk("rst_dm_rdata",  bus_a.dm_rdata_o,   0);
        chk("rst_ce_n",      bus_a.sram_ce_n_o,  1);
        chk("rst_we_n",      bus_a.sram_we_n_o,  1);
        chk("rst_be_n",      bus_a.sram_be_n_o,  4'hF);
        chk("rst_addr",      bus_a.sram_addr_o,  0);
        chk("rst_wdata",     bus_a.sram_wdata_o, 0);
        rst = 1'b0;

        // 1: IF read of byte 0x10 -> word 4
        clk_step(); bus_a.if_req_i = 1; bus_a.if_addr_i = 32'h10; #1;
        chk("t1_if_gnt", bus_a.if_gnt_o, 1);
        chk("t1_dm_gnt", bus_a.dm_gnt_o, 0);
        clk_step(); bus_a.if_req_i = 0; #1;
        chk("t1_ce_n_a", bus_a.sram_ce_n_o, 0);
        chk("t1_we_n",   bus_a.sram_we_n_o, 1);
        chk("t1_be_n",   bus_a.sram_be_n_o, 4'h0);
        chk("t1_addr",   bus_a.sram_addr_o, 32'h4);
        clk_step(); #1;
        chk("t1_ce_n_b",     bus_a.sram_ce_n_o, 0);
        chk("t1_rvalid_early", bus_a.if_rvalid_o, 0);
        clk_step(); #1;
        chk("t1_if_rvalid", bus_a.if_rvalid_o, 1);
        chk("t1_if_rdata",  bus_a.if_rdata_o,  32'h1000_0004);
        chk("t1_ce_n_idle", bus_a.sram_ce_n_o, 1);

        // 2: simultaneous IF read and DM write; DM wins, IF granted alongside dm_rvalid
        clk_step();
        bus_a.if_req_i = 1; bus_a.if_addr_i = 32'h8;
        bus_a.dm_req_i = 1; bus_a.dm_we_i = 1; bus_a.dm_addr_i = 32'h20;
        bus_a.dm_wbe_n_i = 4'b1110; bus_a.dm_wdata_i = 32'hA5; #1;
        chk("t2_dm_gnt", bus_a.dm_gnt_o, 1);
        chk("t2_if_gnt", bus_a.if_gnt_o, 0);
        clk_step(); bus_a.dm_req_i = 0; bus_a.dm_we_i = 0; #1;
        chk("t2_be_n",   bus_a.sram_be_n_o,  4'b1110);
        chk("t2_we_n_a", bus_a.sram_we_n_o,  0);
        chk("t2_ce_n",   bus_a.sram_ce_n_o,  0);
        chk("t2_addr",   bus_a.sram_addr_o,  32'h8);
        chk("t2_wdata",  bus_a.sram_wdata_o, 32'hA5);
        chk("t2_no_if_gnt_access", bus_a.if_gnt_o, 0);
        clk_step(); #1;
        chk("t2_we_n_b", bus_a.sram_we_n_o, 0);
        clk_step(); #1;
        chk("t2_dm_rvalid", bus_a.dm_rvalid_o, 1);
        chk("t2_if_gnt_with_rvalid", bus_a.if_gnt_o, 1);
        chk("t2_dm_rdata_hold", bus_a.dm_rdata_o, 0);
        clk_step(); bus_a.if_req_i = 0; #1;
        clk_step(); #1;
        clk_step(); #1;
        chk("t2_if_rvalid", bus_a.if_rvalid_o, 1);
        chk("t2_if_rdata",  bus_a.if_rdata_o,  32'h1000_0002);

        // 3: DM streams while IF waits -> 4 DM, 1 IF, then DM again
        clk_step();
        bus_a.dm_req_i = 1; bus_a.dm_we_i = 0; bus_a.dm_addr_i = 32'h0;
        bus_a.if_req_i = 1; bus_a.if_addr_i = 32'hC;
        ng = 0; seq = '0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            #1;
            if (bus_a.dm_gnt_o || bus_a.if_gnt_o) begin
                seq[ng] = bus_a.if_gnt_o;
                ng++;
            end
            clk_step();
        end
        chk("t3_grant_count", ng, 6);
        chk("t3_grant_order", seq, 6'b010000);
        bus_a.dm_req_i = 0; bus_a.if_req_i = 0;
        clk_step(); clk_step(); #1;
        chk("t3_dm_rvalid", bus_a.dm_rvalid_o, 1);
        chk("t3_dm_rdata",  bus_a.dm_rdata_o,  32'h1000_0000);

        // 4: write with no bytes enabled never selects the chip
        clk_step();
        bus_a.dm_req_i = 1; bus_a.dm_we_i = 1; bus_a.dm_addr_i = 32'h30;
        bus_a.dm_wbe_n_i = 4'hF; bus_a.dm_wdata_i = 32'hDEAD; #1;
        chk("t4_dm_gnt", bus_a.dm_gnt_o, 1);
        clk_step(); bus_a.dm_req_i = 0; bus_a.dm_we_i = 0; #1;
        chk("t4_ce_n_a", bus_a.sram_ce_n_o, 1);
        clk_step(); #1;
        chk("t4_ce_n_b", bus_a.sram_ce_n_o, 1);
        chk("t4_rvalid_early", bus_a.dm_rvalid_o, 0);
        clk_step(); #1;
        chk("t4_dm_rvalid", bus_a.dm_rvalid_o, 1);
        chk("t4_dm_rdata_hold", bus_a.dm_rdata_o, 32'h1000_0000);
        chk("t4_mem_untouched", mem_a[12], 32'h1000_000C);

        // 5: reset in the second ACCESS cycle drops the read; a reissue completes
        clk_step(); bus_a.dm_req_i = 1; bus_a.dm_addr_i = 32'h20; #1;
        chk("t5_dm_gnt", bus_a.dm_gnt_o, 1);
        clk_step(); bus_a.dm_req_i = 0; #1;
        chk("t5_ce_n_access", bus_a.sram_ce_n_o, 0);
        clk_step(); rst = 1'b1; #1;
        clk_step(); rst = 1'b0; #1;
        chk("t5_ce_n_rst",   bus_a.sram_ce_n_o, 1);
        chk("t5_no_rvalid",  bus_a.dm_rvalid_o, 0);
        chk("t5_rdata_rst",  bus_a.dm_rdata_o,  0);
        chk("t5_addr_rst",   bus_a.sram_addr_o, 0);
        clk_step(); #1;
        chk("t5_no_rvalid_late", bus_a.dm_rvalid_o, 0);
        clk_step(); bus_a.dm_req_i = 1; bus_a.dm_addr_i = 32'h20; #1;
        chk("t5_regnt", bus_a.dm_gnt_o, 1);
        clk_step(); bus_a.dm_req_i = 0; #1;
        clk_step(); #1;
        clk_step(); #1;
        chk("t5_re_rvalid", bus_a.dm_rvalid_o, 1);
        chk("t5_re_rdata",  bus_a.dm_rdata_o,  32'h1000_00A5);

        // 6: SRAM_LAT=1 back-to-back IF reads, one grant every 2 cycles
        clk_step(); bus_b.if_req_i = 1; bus_b.if_addr_i = 32'h0; #1;
        chk("t6_gnt0", bus_b.if_gnt_o, 1);
        clk_step(); bus_b.if_addr_i = 32'h4; #1;
        chk("t6_gap0", bus_b.if_gnt_o, 0);
        chk("t6_ce_n", bus_b.sram_ce_n_o, 0);
        clk_step(); #1;
        chk("t6_rvalid0", bus_b.if_rvalid_o, 1);
        chk("t6_rdata0",  bus_b.if_rdata_o,  32'h2000_0000);
        chk("t6_gnt1",    bus_b.if_gnt_o,    1);
        clk_step(); bus_b.if_addr_i = 32'hFFC0_000B; #1;
        chk("t6_gap1", bus_b.if_gnt_o, 0);
        clk_step(); #1;
        chk("t6_rvalid1", bus_b.if_rvalid_o, 1);
        chk("t6_rdata1",  bus_b.if_rdata_o,  32'h2000_0001);
        chk("t6_gnt2",    bus_b.if_gnt_o,    1);
        clk_step(); bus_b.if_req_i = 0; #1;
        clk_step(); #1;
        chk("t6_rvalid2", bus_b.if_rvalid_o, 1);
        chk("t6_rdata2",  bus_b.if_rdata_o,  32'h2000_0002);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
